// File: rtl/mxv_sequencer.sv
// Control FSM for the matrix-vector multiply datapath: walks row/col indices,
// strobes MAC clear/accumulate, drains the MAC pipeline and writes one result per row.
module mxv_sequencer #(
  parameter int unsigned DIM      = 3,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_operand_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [IDX_W-1:0] o_row_idx,
  output logic [IDX_W-1:0] o_col_idx,
  output logic             o_mac_clr,
  output logic             o_mac_en,
  output logic             o_res_we
);

  localparam int unsigned CntW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DIM - 1);
  localparam logic [CntW-1:0] DrainLast = CntW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StMac,
    StDrain,
    StWrite,
    StDone
  } state_e;

  state_e           r_state, w_state_next;
  logic [IDX_W-1:0] r_row, w_row_next;
  logic [IDX_W-1:0] r_col, w_col_next;
  logic [CntW-1:0]  r_drain, w_drain_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_row   <= '0;
      r_col   <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_next;
      r_row   <= w_row_next;
      r_col   <= w_col_next;
      r_drain <= w_drain_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_row_next   = r_row;
    w_col_next   = r_col;
    w_drain_next = r_drain;
    o_mac_clr    = 1'b0;
    o_mac_en     = 1'b0;
    o_res_we     = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = StClear;
          w_row_next   = '0;
          w_col_next   = '0;
        end
      end
      StClear: begin
        o_mac_clr    = 1'b1;
        w_state_next = StMac;
      end
      StMac: begin
        o_mac_en = i_operand_valid;
        if (i_operand_valid) begin
          if (r_col == LastIdx) begin
            w_col_next = '0;
            // With no pipeline latency the accumulator is already valid next cycle.
            if (PIPE_LAT == 0) begin
              w_state_next = StWrite;
            end else begin
              w_state_next = StDrain;
              w_drain_next = '0;
            end
          end else begin
            w_col_next = r_col + IDX_W'(1);
          end
        end
      end
      StDrain: begin
        if (r_drain == DrainLast) begin
          w_state_next = StWrite;
        end else begin
          w_drain_next = r_drain + CntW'(1);
        end
      end
      StWrite: begin
        o_res_we = 1'b1;
        if (r_row == LastIdx) begin
          w_state_next = StDone;
        end else begin
          w_row_next   = r_row + IDX_W'(1);
          w_state_next = StClear;
        end
      end
      StDone: begin
        o_done       = 1'b1;
        w_row_next   = '0;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_busy    = (r_state != StIdle);
  assign o_row_idx = r_row;
  assign o_col_idx = r_col;

endmodule
